cache_evict_buffer: RTL and testbench
=====================================

Name: cache_evict_buffer

Overview:
- Parametrised eviction write buffer between the L1 data cache and the memory interface.
- Accepts dirty victim lines from L1 in one cycle and drains them to memory in FIFO order.
- Coalesces repeated writes to the same line.
- Serves L1 miss reads that hit a buffered line, so read data is never stale.

Parameters:
LINE_WIDTH, 128, bits per cache line
ADDR_WIDTH, 16, byte address width
OFFSET_BITS, 4, low address bits selecting a byte within a line; forced to zero internally
DEPTH, 4, number of line entries; power of two, at least 2

Ports:
clk  in  1  clock
rst  in  1  reset
wr_valid  in  1  L1 offers a victim line
wr_addr  in  ADDR_WIDTH  victim line address
wr_data  in  LINE_WIDTH  victim line data
wr_ready  out  1  buffer can accept; equals not full
rd_valid  in  1  L1 miss lookup request
rd_addr  in  ADDR_WIDTH  miss address
rd_hit  out  1  lookup matched a buffered line
rd_data  out  LINE_WIDTH  matched line data; zero when no hit
mem_write  out  1  write request to memory
mem_address  out  ADDR_WIDTH  line-aligned head address
mem_wdata  out  LINE_WIDTH  head line data
mem_resp  in  1  memory completed the write
count  out  $clog2(DEPTH)+1  occupied entries
empty  out  1  count == 0

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: all entries invalid; head and tail pointers 0; count 0; empty 1; wr_ready 1; mem_write 0; FSM in IDLE.
- A reset asserted mid-drain abandons the in-flight write, and mem_write is 0 in the following cycle.
- Line address: addr with the low OFFSET_BITS bits cleared. This applies to stored addresses, lookups and mem_address.
- Storage: circular FIFO of DEPTH entries {valid, line_addr, data}. Pointers wrap modulo DEPTH. count distinguishes full from empty.
- Write accept:
  - A write is accepted when wr_valid && wr_ready, in one cycle.
  - Coalesce case: if the line address matches a valid entry that is not the head currently in DRAIN, that entry's data is overwritten in place. count and tail are unchanged.
  - Otherwise the line is pushed at tail: tail+1, count+1.
  - A match against the in-flight head allocates a new entry.
- wr_ready is !full, computed from registered count. It is 0 when full even if the write would coalesce.
- Read lookup is combinational and has no side effects.
  - rd_hit = rd_valid and some valid entry has a matching line address.
  - When several entries match (in-flight head plus a newer copy), the newest entry, closest to tail, supplies rd_data.
  - The lookup sees contents as of the start of the cycle. A write accepted in the same cycle is not forwarded; it is visible from the next cycle.
- Drain FSM:
  - IDLE: mem_write 0. Go to DRAIN when count > 0.
  - DRAIN: mem_write 1. mem_address and mem_wdata come from the head and stay stable until mem_resp. Head data is frozen: no coalescing into it. On mem_resp, pop the head (head+1, count−1) and go to GAP.
  - GAP: mem_write 0 for exactly one cycle. Then go to DRAIN if count > 0, else IDLE.
- Simultaneous push and pop in the same cycle: count is unchanged and both pointers advance.
- A push into the freed slot is not allowed in the pop cycle when the buffer was full, because wr_ready is registered.
- mem_resp outside DRAIN is ignored.
- Drain-to-memory latency: an empty buffer that accepts a write at cycle t asserts mem_write at t+2 (t+1 IDLE sees count > 0, t+2 DRAIN).

Test Plan:
- Reset, then write 0x1230 data A, then write 0x4560 data B; memory responds 3 cycles after each mem_write.
  - Required: mem_address 0x1230 with data A, one cycle of mem_write low, then 0x4560 with data B.
  - Required: count goes 0→1→2→1→0 and empty returns to 1.
- Coalesce: with the FSM held off by mem_resp never asserted and head 0x1000, write 0x2000 data A, then 0x2008 data C.
  - Required: count 2, not 3. The entry for line 0x2000 holds C and is drained as C.
- Fill DEPTH=4 with distinct lines while mem_resp is held low.
  - Required: wr_ready drops to 0 after the fourth accept, and a fifth wr_valid is not accepted.
  - Then pulse mem_resp once. Required: wr_ready returns to 1 in the next cycle.
- Read hit on in-flight head 0x3000 (old data A) with newer entry 0x3000 data D present.
  - Required: rd_valid for 0x300C gives rd_hit 1, rd_data D. A lookup of 0x7000 gives rd_hit 0, rd_data 0.
- Same-cycle write and lookup of 0x5000 into an empty buffer.
  - Required: rd_hit 0 that cycle, rd_hit 1 the next cycle.
- Assert rst while in DRAIN with count 3.
  - Required: the next cycle has mem_write 0, count 0, empty 1, wr_ready 1, and rd_hit 0 for all previously stored lines.

Source files
------------

// File: rtl/cache_evict_buffer.sv
// Eviction write buffer between the L1 data cache and memory: FIFO-ordered drain,
// same-line write coalescing and read forwarding for L1 misses that hit a buffered line.
module cache_evict_buffer #(
  parameter int LINE_WIDTH  = 128,
  parameter int ADDR_WIDTH  = 16,
  parameter int OFFSET_BITS = 4,
  parameter int DEPTH       = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_valid,
  input  logic [ADDR_WIDTH-1:0]        wr_addr,
  input  logic [LINE_WIDTH-1:0]        wr_data,
  output logic                         wr_ready,
  input  logic                         rd_valid,
  input  logic [ADDR_WIDTH-1:0]        rd_addr,
  output logic                         rd_hit,
  output logic [LINE_WIDTH-1:0]        rd_data,
  output logic                         mem_write,
  output logic [ADDR_WIDTH-1:0]        mem_address,
  output logic [LINE_WIDTH-1:0]        mem_wdata,
  input  logic                         mem_resp,
  output logic [$clog2(DEPTH):0]       count,
  output logic                         empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] LINE_MASK =
    {{(ADDR_WIDTH-OFFSET_BITS){1'b1}}, {OFFSET_BITS{1'b0}}};
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    DRAIN,
    GAP
  } state_t;

  state_t state, state_next;

  logic [DEPTH-1:0]      entry_valid;
  logic [ADDR_WIDTH-1:0] entry_addr [DEPTH];
  logic [LINE_WIDTH-1:0] entry_data [DEPTH];

  logic [PTR_W-1:0] head, tail;

  logic [ADDR_WIDTH-1:0] wr_line, rd_line;
  logic                  wr_match, rd_match;
  logic [PTR_W-1:0]      wr_idx, rd_idx, scan_idx;
  logic                  accept, push, pop, coalesce;

  assign wr_line = wr_addr & LINE_MASK;
  assign rd_line = rd_addr & LINE_MASK;

  // Scan from oldest (head) to newest so the last match found is the entry closest to tail.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path leaves one
    // holding its old value and no latch is inferred.
    wr_match = 1'b0;
    wr_idx   = '0;
    rd_match = 1'b0;
    rd_idx   = '0;
    scan_idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = head + PTR_W'(i);
      if (entry_valid[scan_idx] && entry_addr[scan_idx] == wr_line &&
          !(state == DRAIN && scan_idx == head)) begin
        wr_match = 1'b1;
        wr_idx   = scan_idx;
      end
      if (entry_valid[scan_idx] && entry_addr[scan_idx] == rd_line) begin
        rd_match = 1'b1;
        rd_idx   = scan_idx;
      end
    end
  end

  assign wr_ready = (count != FULL_COUNT);
  assign empty    = (count == '0);
  assign accept   = wr_valid && wr_ready;
  assign coalesce = accept && wr_match;
  assign push     = accept && !wr_match;
  assign pop      = (state == DRAIN) && mem_resp;

  assign rd_hit      = rd_valid && rd_match;
  assign rd_data     = rd_hit ? entry_data[rd_idx] : '0;
  assign mem_address = entry_addr[head];
  assign mem_wdata   = entry_data[head];

  always_comb begin
    state_next = state;
    mem_write  = 1'b0;
    unique case (state)
      IDLE: begin
        if (count != '0) state_next = DRAIN;
      end
      DRAIN: begin
        mem_write = 1'b1;
        if (mem_resp) state_next = GAP;
      end
      GAP: begin
        state_next = (count != '0) ? DRAIN : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the values from before this edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      entry_valid <= '0;
    end else begin
      state <= state_next;
      if (pop) begin
        entry_valid[head] <= 1'b0;
        head              <= head + 1'b1;
      end
      if (push) begin
        entry_valid[tail] <= 1'b1;
        tail              <= tail + 1'b1;
      end
      if (push && !pop) begin
        count <= count + 1'b1;
      end else if (pop && !push) begin
        count <= count - 1'b1;
      end
    end
  end

  // NOTE: line storage carries no reset; entry_valid alone decides whether a slot is live,
  // so clearing the wide data and address arrays would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      entry_addr[tail] <= wr_line;
      entry_data[tail] <= wr_data;
    end
    if (coalesce) begin
      entry_data[wr_idx] <= wr_data;
    end
  end

endmodule

// File: tb/tb_cache_evict_buffer.sv
// Directed self-checking bench for cache_evict_buffer: drain order, coalescing,
// full handling, read forwarding and reset during a drain.
module tb_cache_evict_buffer;

  localparam int LW = 128;
  localparam int AW = 16;

  localparam logic [LW-1:0] D_A = {4{32'hAAAA_0001}};
  localparam logic [LW-1:0] D_B = {4{32'hBBBB_0002}};
  localparam logic [LW-1:0] D_C = {4{32'hCCCC_0003}};
  localparam logic [LW-1:0] D_D = {4{32'hDDDD_0004}};
  localparam logic [LW-1:0] D_E = {4{32'hEEEE_0005}};
  localparam logic [LW-1:0] D_X = {4{32'h1234_5678}};

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [AW-1:0] wr_addr;
  logic [LW-1:0] wr_data;
  logic          wr_ready;
  logic          rd_valid;
  logic [AW-1:0] rd_addr;
  logic          rd_hit;
  logic [LW-1:0] rd_data;
  logic          mem_write;
  logic [AW-1:0] mem_address;
  logic [LW-1:0] mem_wdata;
  logic          mem_resp;
  logic [2:0]    count;
  logic          empty;

  int total = 0;
  int bad   = 0;

  cache_evict_buffer #(
    .LINE_WIDTH (LW),
    .ADDR_WIDTH (AW),
    .OFFSET_BITS(4),
    .DEPTH      (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_valid   (wr_valid),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .wr_ready   (wr_ready),
    .rd_valid   (rd_valid),
    .rd_addr    (rd_addr),
    .rd_hit     (rd_hit),
    .rd_data    (rd_data),
    .mem_write  (mem_write),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_resp   (mem_resp),
    .count      (count),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  // Inputs change 1ns after the rising edge; checks follow 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_valid = 1'b0;
    rd_addr  = '0;
    mem_resp = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    rd_valid = 1'b1;
    rd_addr  = 16'h0000;
    #1;
    total++; if (count !== 3'd0)   begin bad++; $display("FAIL reset_count: got %0d want 0", count); end
    total++; if (empty !== 1'b1)   begin bad++; $display("FAIL reset_empty: got %b want 1", empty); end
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL reset_mem_write: got %b want 0", mem_write); end
    total++; if (rd_hit !== 1'b0)  begin bad++; $display("FAIL reset_rd_hit: got %b want 0", rd_hit); end
    total++; if (rd_data !== '0)   begin bad++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
    rd_valid = 1'b0;
  endtask

  task automatic test_drain_order();
    do_reset();
    wr_valid = 1'b1; wr_addr = 16'h1230; wr_data = D_A;
    tick();
    wr_addr = 16'h4560; wr_data = D_B;
    #1;
    total++; if (count !== 3'd1)     begin bad++; $display("FAIL drain_count1: got %0d want 1", count); end
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL drain_latency_t1: got %b want 0", mem_write); end
    tick();
    wr_valid = 1'b0;
    #1;
    total++; if (count !== 3'd2)     begin bad++; $display("FAIL drain_count2: got %0d want 2", count); end
    total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL drain_latency_t2: got %b want 1", mem_write); end
    total++; if (mem_address !== 16'h1230) begin bad++; $display("FAIL drain_addr_a: got %h want 1230", mem_address); end
    total++; if (mem_wdata !== D_A)  begin bad++; $display("FAIL drain_data_a: got %h want %h", mem_wdata, D_A); end
    tick();
    tick();
    tick();
    mem_resp = 1'b1;
    #1;
    total++; if (mem_write !== 1'b1 || mem_address !== 16'h1230)
      begin bad++; $display("FAIL drain_hold_a: got %b/%h want 1/1230", mem_write, mem_address); end
    tick();
    mem_resp = 1'b0;
    #1;
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL drain_gap: got %b want 0", mem_write); end
    total++; if (count !== 3'd1)     begin bad++; $display("FAIL drain_count_pop1: got %0d want 1", count); end
    tick();
    total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL drain_second_write: got %b want 1", mem_write); end
    total++; if (mem_address !== 16'h4560) begin bad++; $display("FAIL drain_addr_b: got %h want 4560", mem_address); end
    total++; if (mem_wdata !== D_B)  begin bad++; $display("FAIL drain_data_b: got %h want %h", mem_wdata, D_B); end
    tick();
    tick();
    tick();
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    #1;
    total++; if (count !== 3'd0)     begin bad++; $display("FAIL drain_count_end: got %0d want 0", count); end
    total++; if (empty !== 1'b1)     begin bad++; $display("FAIL drain_empty_end: got %b want 1", empty); end
    tick();
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL drain_idle_end: got %b want 0", mem_write); end
  endtask

  task automatic test_coalesce();
    do_reset();
    wr_valid = 1'b1; wr_addr = 16'h1000; wr_data = D_X;
    tick();
    wr_addr = 16'h2000; wr_data = D_A;
    tick();
    wr_addr = 16'h2008; wr_data = D_C;
    tick();
    wr_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 16'h2000;
    #1;
    total++; if (count !== 3'd2)    begin bad++; $display("FAIL coalesce_count: got %0d want 2", count); end
    total++; if (rd_hit !== 1'b1 || rd_data !== D_C)
      begin bad++; $display("FAIL coalesce_lookup: got %b/%h want 1/%h", rd_hit, rd_data, D_C); end
    total++; if (mem_address !== 16'h1000) begin bad++; $display("FAIL coalesce_head: got %h want 1000", mem_address); end
    rd_valid = 1'b0;
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    tick();
    total++; if (mem_write !== 1'b1 || mem_address !== 16'h2000)
      begin bad++; $display("FAIL coalesce_drain_addr: got %b/%h want 1/2000", mem_write, mem_address); end
    total++; if (mem_wdata !== D_C) begin bad++; $display("FAIL coalesce_drain_data: got %h want %h", mem_wdata, D_C); end
  endtask

  task automatic test_full();
    logic [AW-1:0] lines [4];
    lines[0] = 16'h1000; lines[1] = 16'h2000; lines[2] = 16'h3000; lines[3] = 16'h4000;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_addr = lines[i]; wr_data = D_X;
      #1;
      total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL full_ready_%0d: got %b want 1", i, wr_ready); end
      tick();
    end
    total++; if (count !== 3'd4)    begin bad++; $display("FAIL full_count4: got %0d want 4", count); end
    total++; if (wr_ready !== 1'b0) begin bad++; $display("FAIL full_ready_low: got %b want 0", wr_ready); end
    wr_addr = 16'h5000; wr_data = D_E;
    tick();
    rd_valid = 1'b1; rd_addr = 16'h5000;
    #1;
    total++; if (count !== 3'd4)    begin bad++; $display("FAIL full_fifth_count: got %0d want 4", count); end
    total++; if (rd_hit !== 1'b0)   begin bad++; $display("FAIL full_fifth_absent: got %b want 0", rd_hit); end
    mem_resp = 1'b1;
    tick();
    mem_resp = 1'b0;
    #1;
    total++; if (wr_ready !== 1'b1) begin bad++; $display("FAIL full_ready_back: got %b want 1", wr_ready); end
    total++; if (count !== 3'd3)    begin bad++; $display("FAIL full_count_pop: got %0d want 3", count); end
    total++; if (rd_hit !== 1'b0)   begin bad++; $display("FAIL full_pop_cycle_push: got %b want 0", rd_hit); end
    tick();
    wr_valid = 1'b0;
    #1;
    total++; if (count !== 3'd4)    begin bad++; $display("FAIL full_refill_count: got %0d want 4", count); end
    total++; if (rd_hit !== 1'b1 || rd_data !== D_E)
      begin bad++; $display("FAIL full_refill_lookup: got %b/%h want 1/%h", rd_hit, rd_data, D_E); end
    rd_addr = 16'h1000;
    #1;
    total++; if (rd_hit !== 1'b0)   begin bad++; $display("FAIL full_popped_gone: got %b want 0", rd_hit); end
    rd_valid = 1'b0;
  endtask

  task automatic test_read_hit();
    do_reset();
    wr_valid = 1'b1; wr_addr = 16'h3000; wr_data = D_A;
    tick();
    wr_valid = 1'b0;
    tick();
    total++; if (mem_write !== 1'b1) begin bad++; $display("FAIL rdhit_inflight: got %b want 1", mem_write); end
    wr_valid = 1'b1; wr_addr = 16'h3004; wr_data = D_D;
    tick();
    wr_valid = 1'b0;
    rd_valid = 1'b1; rd_addr = 16'h300C;
    #1;
    total++; if (count !== 3'd2)    begin bad++; $display("FAIL rdhit_alloc_count: got %0d want 2", count); end
    total++; if (rd_hit !== 1'b1 || rd_data !== D_D)
      begin bad++; $display("FAIL rdhit_newest: got %b/%h want 1/%h", rd_hit, rd_data, D_D); end
    total++; if (mem_wdata !== D_A) begin bad++; $display("FAIL rdhit_head_frozen: got %h want %h", mem_wdata, D_A); end
    rd_addr = 16'h7000;
    #1;
    total++; if (rd_hit !== 1'b0 || rd_data !== '0)
      begin bad++; $display("FAIL rdhit_miss: got %b/%h want 0/0", rd_hit, rd_data); end
    rd_valid = 1'b0;
  endtask

  task automatic test_same_cycle();
    do_reset();
    wr_valid = 1'b1; wr_addr = 16'h5000; wr_data = D_E;
    rd_valid = 1'b1; rd_addr = 16'h5000;
    #1;
    total++; if (rd_hit !== 1'b0)  begin bad++; $display("FAIL same_cycle_no_fwd: got %b want 0", rd_hit); end
    tick();
    wr_valid = 1'b0;
    #1;
    total++; if (rd_hit !== 1'b1 || rd_data !== D_E)
      begin bad++; $display("FAIL same_cycle_next: got %b/%h want 1/%h", rd_hit, rd_data, D_E); end
    rd_valid = 1'b0;
  endtask

  task automatic test_reset_mid_drain();
    logic [AW-1:0] lines [3];
    lines[0] = 16'h1000; lines[1] = 16'h2000; lines[2] = 16'h3000;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      wr_valid = 1'b1; wr_addr = lines[i]; wr_data = D_B;
      tick();
    end
    wr_valid = 1'b0;
    #1;
    total++; if (count !== 3'd3 || mem_write !== 1'b1)
      begin bad++; $display("FAIL rstmid_pre: got %0d/%b want 3/1", count, mem_write); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    total++; if (mem_write !== 1'b0) begin bad++; $display("FAIL rstmid_mem_write: got %b want 0", mem_write); end
    total++; if (count !== 3'd0)     begin bad++; $display("FAIL rstmid_count: got %0d want 0", count); end
    total++; if (empty !== 1'b1)     begin bad++; $display("FAIL rstmid_empty: got %b want 1", empty); end
    total++; if (wr_ready !== 1'b1)  begin bad++; $display("FAIL rstmid_wr_ready: got %b want 1", wr_ready); end
    rd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rd_addr = lines[i];
      #1;
      total++; if (rd_hit !== 1'b0) begin bad++; $display("FAIL rstmid_lookup_%0d: got %b want 0", i, rd_hit); end
    end
    rd_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_drain_order();
    test_coalesce();
    test_full();
    test_read_hit();
    test_same_cycle();
    test_reset_mid_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
